// File: rtl/vdp_pkg.sv
// Shared draw-side VDP types and constants.
// Used by tile_line_fetcher (optional build macro: TILE_FETCH_SCROLL_EN).
package vdp_pkg;

   localparam int unsigned TILES_PER_LINE = 32;
   localparam int unsigned QUADS_PER_LINE = 64;
   localparam int unsigned TX_W           = 5;

   typedef logic [9:0]  tile_idx_t;
   typedef logic [15:0] tile_quad_t;

   typedef enum logic [2:0] {
      TLF_IDLE = 3'd0,
      TLF_MAP  = 3'd1,
      TLF_IDX  = 3'd2,
      TLF_COL0 = 3'd3,
      TLF_COL1 = 3'd4,
      TLF_DONE = 3'd5
   } tlf_state_t;

endpackage

// File: rtl/tile_line_fetcher.sv
// Walks one 256-pixel scanline of the 32x32 tile map and fills the 64-quad line buffer.
// Build macro TILE_FETCH_SCROLL_EN enables the coarse scroll inputs; otherwise they read as 0.
module tile_line_fetcher
   import vdp_pkg::*;
#(
   parameter int MAP_LATENCY = 1
) (
   input  logic        clk_draw,
   input  logic        rst_draw_n,
   input  logic        line_start,
   input  logic [7:0]  line_y,
   input  logic [4:0]  scroll_tx,
   input  logic [4:0]  scroll_ty,
   output logic        busy,
   output logic        done,
   output logic [9:0]  map_addr,
   input  logic [9:0]  map_data,
   output logic [9:0]  tile_index,
   output logic [2:0]  tile_row,
   output logic        tile_col,
   input  logic [15:0] tile_data,
   output logic        lb_we,
   output logic [5:0]  lb_addr,
   output logic [15:0] lb_data
);

   if (MAP_LATENCY != 1) begin : g_bad_map_latency
      $error("tile_line_fetcher: only MAP_LATENCY == 1 is supported");
   end

   localparam logic [2:0] ST_IDLE = 3'(TLF_IDLE);
   localparam logic [2:0] ST_MAP  = 3'(TLF_MAP);
   localparam logic [2:0] ST_IDX  = 3'(TLF_IDX);
   localparam logic [2:0] ST_COL0 = 3'(TLF_COL0);
   localparam logic [2:0] ST_COL1 = 3'(TLF_COL1);
   localparam logic [2:0] ST_DONE = 3'(TLF_DONE);

   logic [TX_W-1:0] scroll_tx_eff;
   logic [TX_W-1:0] scroll_ty_eff;

`ifdef TILE_FETCH_SCROLL_EN
   assign scroll_tx_eff = scroll_tx;
   assign scroll_ty_eff = scroll_ty;
`else
   logic unused_scroll;
   assign scroll_tx_eff = '0;
   assign scroll_ty_eff = '0;
   assign unused_scroll = ^{scroll_tx, scroll_ty};
`endif

   logic [2:0]      state_q,     state_d;
   logic [TX_W-1:0] screen_tx_q, screen_tx_d;
   logic [TX_W-1:0] map_ty_q,    map_ty_d;
   logic [TX_W-1:0] scroll_tx_q, scroll_tx_d;
   logic [2:0]      row_q,       row_d;
   logic [TX_W-1:0] lb_tx_q,     lb_tx_d;
   logic            pend_q,      pend_d;
   logic            busy_d, done_d, lb_we_d, tile_col_d;
   logic [9:0]      map_addr_d;
   tile_idx_t       tile_index_d;
   logic [2:0]      tile_row_d;
   logic [TX_W-1:0] start_ty;

   // Quad address low bit is the pending flag: 0 for the COL0 write, 1 for the COL1 write.
   assign lb_addr  = {lb_tx_q, pend_q};
   assign lb_data  = lb_we ? tile_data : '0;
   assign start_ty = TX_W'(line_y[7:3] + scroll_ty_eff);

   // Next-state and next-output decode; outputs are registered one edge ahead of their state.
   always_comb begin
      state_d      = state_q;
      screen_tx_d  = screen_tx_q;
      map_ty_d     = map_ty_q;
      scroll_tx_d  = scroll_tx_q;
      row_d        = row_q;
      lb_tx_d      = lb_tx_q;
      pend_d       = 1'b0;
      busy_d       = busy;
      done_d       = 1'b0;
      lb_we_d      = 1'b0;
      map_addr_d   = map_addr;
      tile_index_d = tile_index;
      tile_row_d   = tile_row;
      tile_col_d   = tile_col;

      case (state_q)
         ST_IDLE: begin
            if (line_start) begin
               row_d       = line_y[2:0];
               map_ty_d    = start_ty;
               scroll_tx_d = scroll_tx_eff;
               screen_tx_d = '0;
               map_addr_d  = {start_ty, scroll_tx_eff};
               busy_d      = 1'b1;
               state_d     = ST_MAP;
            end
         end
         ST_MAP: begin
            state_d = ST_IDX;
         end
         ST_IDX: begin
            tile_index_d = map_data;
            tile_row_d   = row_q;
            tile_col_d   = 1'b0;
            state_d      = ST_COL0;
         end
         ST_COL0: begin
            tile_col_d = 1'b1;
            lb_we_d    = 1'b1;
            lb_tx_d    = screen_tx_q;
            state_d    = ST_COL1;
         end
         ST_COL1: begin
            lb_we_d = 1'b1;
            pend_d  = 1'b1;
            if (screen_tx_q == TX_W'(TILES_PER_LINE - 1)) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               screen_tx_d = TX_W'(screen_tx_q + 1'b1);
               map_addr_d  = {map_ty_q, TX_W'(screen_tx_q + 1'b1 + scroll_tx_q)};
               state_d     = ST_MAP;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_draw) begin
      if (!rst_draw_n) begin
         state_q     <= ST_IDLE;
         screen_tx_q <= '0;
         map_ty_q    <= '0;
         scroll_tx_q <= '0;
         row_q       <= '0;
         lb_tx_q     <= '0;
         pend_q      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         lb_we       <= 1'b0;
         map_addr    <= '0;
         tile_index  <= '0;
         tile_row    <= '0;
         tile_col    <= 1'b0;
      end else begin
         state_q     <= state_d;
         screen_tx_q <= screen_tx_d;
         map_ty_q    <= map_ty_d;
         scroll_tx_q <= scroll_tx_d;
         row_q       <= row_d;
         lb_tx_q     <= lb_tx_d;
         pend_q      <= pend_d;
         busy        <= busy_d;
         done        <= done_d;
         lb_we       <= lb_we_d;
         map_addr    <= map_addr_d;
         tile_index  <= tile_index_d;
         tile_row    <= tile_row_d;
         tile_col    <= tile_col_d;
      end
   end

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Directed bench for tile_line_fetcher with behavioural map RAM (map[i] = i) and tile ROM.
module tb_tile_line_fetcher;

   logic        clk_draw = 1'b0;
   logic        rst_draw_n;
   logic        line_start;
   logic [7:0]  line_y;
   logic [4:0]  scroll_tx;
   logic [4:0]  scroll_ty;
   logic        busy;
   logic        done;
   logic [9:0]  map_addr;
   logic [9:0]  map_data;
   logic [9:0]  tile_index;
   logic [2:0]  tile_row;
   logic        tile_col;
   logic [15:0] tile_data;
   logic        lb_we;
   logic [5:0]  lb_addr;
   logic [15:0] lb_data;

   always #5 clk_draw = ~clk_draw;

   tile_line_fetcher #(.MAP_LATENCY(1)) dut (
      .clk_draw   (clk_draw),
      .rst_draw_n (rst_draw_n),
      .line_start (line_start),
      .line_y     (line_y),
      .scroll_tx  (scroll_tx),
      .scroll_ty  (scroll_ty),
      .busy       (busy),
      .done       (done),
      .map_addr   (map_addr),
      .map_data   (map_data),
      .tile_index (tile_index),
      .tile_row   (tile_row),
      .tile_col   (tile_col),
      .tile_data  (tile_data),
      .lb_we      (lb_we),
      .lb_addr    (lb_addr),
      .lb_data    (lb_data)
   );

   // One-cycle-latency memories: identity map, ROM word = {idx, row, col, 2'b10}.
   always @(posedge clk_draw) begin
      map_data  <= map_addr;
      tile_data <= {tile_index, tile_row, tile_col, 2'b10};
   end

   logic [15:0] lb_mem [64];
   logic [5:0]  exp_addr = '0;
   int          n_writes = 0;
   int          n_done = 0;
   int          order_err = 0;

   always @(negedge clk_draw) begin
      if (!rst_draw_n) begin
         exp_addr <= '0;
      end else begin
         if (lb_we) begin
            lb_mem[lb_addr] <= lb_data;
            n_writes        <= n_writes + 1;
            if (lb_addr != exp_addr) order_err <= order_err + 1;
            exp_addr        <= exp_addr + 6'd1;
         end
         if (done) n_done <= n_done + 1;
      end
   end

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [15:0] exp_quad(input logic [4:0] ty, input logic [4:0] stx,
                                            input logic [2:0] row, input int a);
      logic [4:0] k;
      logic [4:0] x;
      k = 5'(a >> 1);
      x = 5'(k + stx);
      return {ty, x, row, a[0], 2'b10};
   endfunction

   int w0, d0, e0;
   int done_first, done_last, busy_first, busy_after;

   // Pulses line_start for one cycle, then runs win cycles; p1/p2 re-pulse it at those cycle offsets.
   task automatic run_line(input logic [7:0] y, input logic [4:0] stx, input logic [4:0] sty,
                           input int p1, input int p2, input int win);
      w0 = n_writes; d0 = n_done; e0 = order_err;
      done_first = -1; done_last = -1; busy_first = 0; busy_after = 1;
      line_y = y; scroll_tx = stx; scroll_ty = sty; line_start = 1'b1;
      for (int c = 1; c <= win; c++) begin
         @(posedge clk_draw); #1;
         line_start = (c == p1) || (c == p2);
         if (done) begin
            if (done_first < 0) done_first = c;
            done_last = c;
         end
         if (c == 1) busy_first = int'(busy);
         if (done_first > 0 && c == done_first + 1) busy_after = int'(busy);
      end
      line_start = 1'b0;
   endtask

   logic [4:0] sc_ty, sc_tx;

   initial begin
      rst_draw_n = 1'b0; line_start = 1'b0; line_y = '0; scroll_tx = '0; scroll_ty = '0;
      repeat (3) @(posedge clk_draw);
      #1;
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_lb_we", 32'(lb_we), 0);
      chk("reset_map_addr", 32'(map_addr), 0);
      chk("reset_tile_index", 32'(tile_index), 0);
      chk("reset_lb_addr", 32'(lb_addr), 0);
      chk("reset_lb_data", 32'(lb_data), 0);
      rst_draw_n = 1'b1;
      @(posedge clk_draw); #1;

      // Basic line: y = 0x13 -> map row 2, tile row 3.
      run_line(8'h13, 5'd0, 5'd0, 0, 0, 160);
      chk("basic_writes", 32'(n_writes - w0), 64);
      chk("basic_order", 32'(order_err - e0), 0);
      chk("basic_done_count", 32'(n_done - d0), 1);
      chk("basic_line_cycles", 32'(done_first + 1), 130);
      chk("basic_busy_first", 32'(busy_first), 1);
      chk("basic_busy_after_done", 32'(busy_after), 0);
      chk("basic_quad0", 32'(lb_mem[0]), 32'h101A);
      chk("basic_quad63", 32'(lb_mem[63]), 32'h17DE);
      for (int a = 0; a < 64; a++)
         chk($sformatf("basic_quad_%0d", a), 32'(lb_mem[a]), 32'(exp_quad(5'd2, 5'd0, 3'd3, a)));

      // Scroll: y = 0xF8, scroll_tx = 30, scroll_ty = 3.
      run_line(8'hF8, 5'd30, 5'd3, 0, 0, 160);
`ifdef TILE_FETCH_SCROLL_EN
      sc_ty = 5'd2; sc_tx = 5'd30;
      chk("scroll_quad0", 32'(lb_mem[0]), 32'h1782);
      chk("scroll_quad4_wrap", 32'(lb_mem[4]), 32'h1002);
      chk("scroll_quad63", 32'(lb_mem[63]), 32'h1746);
`else
      sc_ty = 5'd31; sc_tx = 5'd0;
      chk("noscroll_quad0", 32'(lb_mem[0]), 32'hF802);
      chk("noscroll_quad4", 32'(lb_mem[4]), 32'hF882);
      chk("noscroll_quad63", 32'(lb_mem[63]), 32'hFFC6);
`endif
      chk("scroll_writes", 32'(n_writes - w0), 64);
      chk("scroll_tile_row", 32'(tile_row), 0);
      for (int a = 0; a < 64; a++)
         chk($sformatf("scroll_quad_%0d", a), 32'(lb_mem[a]), 32'(exp_quad(sc_ty, sc_tx, 3'd0, a)));

      // Starts while busy and on the done cycle are both ignored.
      run_line(8'h13, 5'd0, 5'd0, 50, 129, 170);
      chk("busystart_writes", 32'(n_writes - w0), 64);
      chk("busystart_done_count", 32'(n_done - d0), 1);
      chk("busystart_order", 32'(order_err - e0), 0);
      chk("busystart_line_cycles", 32'(done_first + 1), 130);
      chk("busystart_idle_after", 32'(busy), 0);

      // Reset mid-line after 70 cycles: 17 tiles fully written (34 quads) before it.
      w0 = n_writes; d0 = n_done;
      line_y = 8'h13; scroll_tx = '0; scroll_ty = '0; line_start = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         @(posedge clk_draw); #1;
         line_start = 1'b0;
      end
      chk("midrst_busy_before", 32'(busy), 1);
      rst_draw_n = 1'b0;
      @(posedge clk_draw); #1;
      chk("midrst_lb_we", 32'(lb_we), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_map_addr", 32'(map_addr), 0);
      chk("midrst_tile_index", 32'(tile_index), 0);
      chk("midrst_tile_row", 32'(tile_row), 0);
      chk("midrst_tile_col", 32'(tile_col), 0);
      chk("midrst_lb_addr", 32'(lb_addr), 0);
      chk("midrst_lb_data", 32'(lb_data), 0);
      rst_draw_n = 1'b1;
      repeat (20) @(posedge clk_draw);
      #1;
      chk("midrst_writes_before", 32'(n_writes - w0), 34);
      chk("midrst_no_done", 32'(n_done - d0), 0);
      run_line(8'h13, 5'd0, 5'd0, 0, 0, 160);
      chk("midrst_restart_writes", 32'(n_writes - w0), 64);
      chk("midrst_restart_order", 32'(order_err - e0), 0);
      chk("midrst_restart_done", 32'(n_done - d0), 1);
      chk("midrst_restart_cycles", 32'(done_first + 1), 130);

      // Back-to-back: second start on the cycle after done; y = 0x21 -> map row 4, tile row 1.
      run_line(8'h21, 5'd0, 5'd0, 130, 0, 300);
      chk("b2b_writes", 32'(n_writes - w0), 128);
      chk("b2b_order", 32'(order_err - e0), 0);
      chk("b2b_done_count", 32'(n_done - d0), 2);
      chk("b2b_first_cycles", 32'(done_first + 1), 130);
      chk("b2b_total_cycles", 32'(done_last + 1), 260);
      chk("b2b_quad5", 32'(lb_mem[5]), 32'h208E);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
